// File: rtl/hdmi_rx_decoder_if.sv
// rtl/hdmi_rx_decoder_if.sv - AXI4-Stream video bus driven by hdmi_rx_decoder
interface hdmi_rx_decoder_if;
  logic [31:0] tdata;
  logic        tvalid;
  logic        tready;
  logic        tuser;
  logic        tlast;

  modport master (output tdata, output tvalid, output tuser, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tuser, input tlast, output tready);
endinterface

// File: rtl/hdmi_rx_decoder.sv
// rtl/hdmi_rx_decoder.sv - TMDS (DVI) decode, video framing and output FIFO
module hdmi_rx_decoder #(
  parameter int FIFO_DEPTH = 64,
  parameter bit VSYNC_POL  = 1'b1
) (
  input  logic              px_clk_i,
  input  logic              rst_n_i,
  input  logic [9:0]        tmds_ch0_i,
  input  logic [9:0]        tmds_ch1_i,
  input  logic [9:0]        tmds_ch2_i,
  hdmi_rx_decoder_if.master video_o,
  output logic              overflow_o,
  input  logic              clr_ovf_i
);
  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic {PASS, DROP} drop_state_t;

  function automatic logic [7:0] tmds_decode(input logic [9:0] q);
    logic [7:0] b;
    logic [7:0] d;
    b    = q[9] ? ~q[7:0] : q[7:0];
    d[0] = b[0];
    for (int i = 1; i < 8; i++) d[i] = q[8] ? (b[i] ^ b[i-1]) : ~(b[i] ^ b[i-1]);
    return d;
  endfunction

  logic       ctrl_tok;
  logic [1:0] ctrl_c;

  always_comb begin
    ctrl_tok = 1'b1;
    ctrl_c   = 2'b00;
    case (tmds_ch0_i)
      10'b1101010100: ctrl_c = 2'b00;
      10'b0010101011: ctrl_c = 2'b01;
      10'b0101010100: ctrl_c = 2'b10;
      10'b1010101011: ctrl_c = 2'b11;
      default:        ctrl_tok = 1'b0;
    endcase
  end

  logic [23:0] s1_pix;
  logic        s1_de, s1_hs, s1_vs;
  logic        vs_act_q, sof_armed;
  logic [23:0] s2_pix;
  logic        s2_valid, s2_user;
  logic        s1_vs_act;

  assign s1_vs_act = (s1_vs == VSYNC_POL);

  // Sync levels are held through active video so edge detection only sees blanking.
  always_ff @(posedge px_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      s1_pix    <= '0;
      s1_de     <= 1'b0;
      s1_hs     <= 1'b0;
      s1_vs     <= 1'b0;
      vs_act_q  <= ~VSYNC_POL;
      sof_armed <= 1'b0;
      s2_pix    <= '0;
      s2_valid  <= 1'b0;
      s2_user   <= 1'b0;
    end else begin
      s1_de  <= ~ctrl_tok;
      s1_pix <= {tmds_decode(tmds_ch2_i), tmds_decode(tmds_ch1_i), tmds_decode(tmds_ch0_i)};
      if (ctrl_tok) begin
        s1_hs <= ctrl_c[0];
        s1_vs <= ctrl_c[1];
      end
      vs_act_q <= s1_vs_act;
      if (s1_vs_act && !vs_act_q) sof_armed <= 1'b1;
      else if (s1_de)             sof_armed <= 1'b0;
      s2_valid <= s1_de;
      if (s1_de) begin
        s2_pix  <= s1_pix;
        s2_user <= sof_armed;
      end
    end
  end

  logic [33:0]  mem [FIFO_DEPTH];
  logic [AW:0]  wr_ptr, rd_ptr;
  logic [33:0]  head;
  logic         empty, full, rd_en, wr_try, ovf_evt, wr_en;
  drop_state_t  drop_q, drop_d;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rd_en   = video_o.tvalid && video_o.tready;
  // The stage-2 pixel leaves whenever a lookahead word sits in stage 1, i.e. every cycle.
  assign wr_try  = s2_valid && ((drop_q == PASS) || s2_user);
  assign ovf_evt = wr_try && full && !rd_en;
  assign wr_en   = wr_try && !ovf_evt;

  always_comb begin
    drop_d = drop_q;
    if (ovf_evt)                drop_d = DROP;
    else if (wr_en && s2_user)  drop_d = PASS;
  end

  always_ff @(posedge px_clk_i) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= {8'h00, s2_pix, s2_user, ~s1_de};
  end

  always_ff @(posedge px_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      drop_q     <= PASS;
      overflow_o <= 1'b0;
    end else begin
      drop_q <= drop_d;
      if (wr_en) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (rd_en) rd_ptr <= rd_ptr + (AW+1)'(1);
      if (ovf_evt)        overflow_o <= 1'b1;
      else if (clr_ovf_i) overflow_o <= 1'b0;
    end
  end

  assign head           = empty ? '0 : mem[rd_ptr[AW-1:0]];
  assign video_o.tvalid = ~empty;
  assign video_o.tdata  = head[33:2];
  assign video_o.tuser  = head[1];
  assign video_o.tlast  = head[0];
endmodule

// File: doc/hdmi_rx_decoder.md
Name: hdmi_rx_decoder

Overview:
Receive-side counterpart of the HDMI transmit path. It accepts three already-deserialized 10-bit TMDS words per pixel clock and decodes control tokens and 8b/10b video data. It rebuilds active-video framing and emits pixels as an AXI4-Stream with tuser marking start of frame and tlast marking end of line. It sits between the deserializer/word-aligner and downstream video processing; an output FIFO absorbs AXI backpressure because the TMDS source cannot be stalled.

Parameters:
FIFO_DEPTH, 64, output FIFO depth in pixels; power of two, at least 4
VSYNC_POL, 1, active level of decoded vsync (1 = active-high)

Ports:
px_clk_i  input  1  pixel clock; all logic in this domain
rst_n_i  input  1  asynchronous active-low reset
tmds_ch0_i  input  10  channel 0 word (blue; carries hsync/vsync as C0/C1)
tmds_ch1_i  input  10  channel 1 word (green)
tmds_ch2_i  input  10  channel 2 word (red)
video_o_tdata  output  32  {8'h00, R, G, B}
video_o_tvalid  output  1  pixel valid
video_o_tready  input  1  downstream ready
video_o_tuser  output  1  first pixel of frame
video_o_tlast  output  1  last pixel of line
overflow_o  output  1  sticky FIFO-overflow flag
clr_ovf_i  input  1  clears overflow_o; single-cycle pulse

Behaviour:
- Reset (async assert, sync release): tvalid=0, tuser=0, tlast=0, tdata=0, overflow_o=0, FIFO empty, sof_armed=0, drop state=PASS.
- Control tokens, per channel: 1101010100->C=00, 0010101011->C=01, 0101010100->C=10, 1010101011->C=11. On ch0, C[0]=hsync and C[1]=vsync.
- DE=0 when ch0 is a control token; otherwise DE=1. DVI-mode only: data islands and guard bands are not recognised, and TERC4 words are treated as video.
- Data decode for word q: if q[9]=1, invert q[7:0]. Then d[0]=q[0]. For i>=1, d[i]=q[i]^q[i-1] when q[8]=1, and d[i]=~(q[i]^q[i-1]) when q[8]=0.
- Stage 1 registers the decoded pixel, DE, hsync and vsync.
- Stage 2 holds one pixel of lookahead: a pixel with DE=1 gets tlast=1 when the following stage-1 DE=0.
- Frame start: on the transition of vsync into its active level (VSYNC_POL), sof_armed is set. The first DE=1 pixel after that gets tuser=1 and clears sof_armed.
- Only DE=1 pixels are written to the FIFO, with 34 bits per entry (tdata, tuser, tlast).
- Latency: with the FIFO empty and tready=1, a pixel is on video_o_tdata with tvalid=1 exactly 3 px_clk_i cycles after its TMDS words are at the inputs.
- A line whose last pixel is still waiting for lookahead stays in stage 2 until the next DE=0 or DE=1 word; no timeout.
- AXI rules: tvalid, tdata, tuser and tlast stay stable while tvalid=1 and tready=0. A transfer occurs when tvalid&tready. The FIFO supports a simultaneous read and write when full: a read in the same cycle frees the slot for the write.
- Overflow: a write attempt while the FIFO is full and there is no same-cycle read does the following:
  - the pixel is dropped and overflow_o is set;
  - the drop state becomes DROP: all writes are discarded until the next pixel carrying tuser, which is written and returns the state to PASS;
  - FIFO contents already queued still drain normally.
- clr_ovf_i clears overflow_o. If clr_ovf_i and a new overflow occur in the same cycle, overflow_o stays set.
- A vsync edge while a line is in progress does not truncate it; tlast is still produced by the DE fall.

Test Plan:
- Control decode: ch0=0010101011, then 1010101011, then 1101010100 -> internal hsync/vsync = 1/0, 1/1, 0/0; no FIFO writes, tvalid stays 0.
- Data decode: all channels 0x100 -> tdata=0x00000000. ch2=0x2FF, ch1=0x100, ch0=0x100 -> tdata=0x00FE0000. Each pixel appears 3 cycles after input with tready=1.
- Line framing: 4 DE pixels then control tokens, tready=1 -> 4 beats, tlast=1 only on beat 4, tuser=0 with no preceding vsync.
- Frame framing: vsync pulse, then 2 lines of 3 pixels -> 6 beats, tuser=1 only on beat 1, tlast on beats 3 and 6.
- Overflow: FIFO_DEPTH=4, tready=0, frame with one line of 8 pixels -> 4 pixels queued, overflow_o=1. Then tready=1 -> exactly those 4 beats drain. Next frame delivers all pixels starting with tuser=1. A clr_ovf_i pulse -> overflow_o=0.
- Reset mid-line: assert rst_n_i during pixel 2 of a 4-pixel line -> tvalid=0 immediately (asynchronously). After release, the partial line never appears; the next frame starts cleanly with tuser=1.
